// File: rtl/multicycle_ctrl_pkg.sv
// ============================================================================
// Module   : mctrl_pkg
// Brief    : State encoding, IR field constants and datapath select encodings
//            shared by the multicycle MIPS-subset control FSM.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mctrl_pkg;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_EXEC   = 4'd6,
      ST_RWB    = 4'd7,
      ST_BRANCH = 4'd8,
      ST_ADDIEX = 4'd9,
      ST_ADDIWB = 4'd10,
      ST_JUMP   = 4'd11,
      ST_HALT   = 4'd12
   } state_e;

   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_lw    = 6'b100011;
   localparam logic [5:0] c_op_sw    = 6'b101011;
   localparam logic [5:0] c_op_beq   = 6'b000100;
   localparam logic [5:0] c_op_bne   = 6'b000101;
   localparam logic [5:0] c_op_addi  = 6'b001000;
   localparam logic [5:0] c_op_j     = 6'b000010;

   localparam logic [5:0] c_fn_add = 6'b100000;
   localparam logic [5:0] c_fn_sub = 6'b100010;
   localparam logic [5:0] c_fn_and = 6'b100100;
   localparam logic [5:0] c_fn_or  = 6'b100101;
   localparam logic [5:0] c_fn_slt = 6'b101010;
   localparam logic [5:0] c_fn_nor = 6'b100111;

   localparam logic [3:0] c_alu_and = 4'b0000;
   localparam logic [3:0] c_alu_or  = 4'b0001;
   localparam logic [3:0] c_alu_add = 4'b0010;
   localparam logic [3:0] c_alu_sub = 4'b0110;
   localparam logic [3:0] c_alu_slt = 4'b0111;
   localparam logic [3:0] c_alu_nor = 4'b1100;

   localparam logic [1:0] c_pcsrc_alu    = 2'b00;
   localparam logic [1:0] c_pcsrc_aluout = 2'b01;
   localparam logic [1:0] c_pcsrc_jump   = 2'b10;

   localparam logic [1:0] c_srcb_b     = 2'b00;
   localparam logic [1:0] c_srcb_four  = 2'b01;
   localparam logic [1:0] c_srcb_imm   = 2'b10;
   localparam logic [1:0] c_srcb_immsh = 2'b11;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       ir_we;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_ctl;
      logic       reg_we;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       error;
   } ctrl_t;

   // States that own the memory port and therefore run the wait counter.
   function automatic logic is_mem_state(state_e s);
      return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
   endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
// Module   : multicycle_ctrl_if
// Brief    : Control/datapath bundle between the multicycle FSM (master) and
//            the datapath plus memory port (slave).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if;
   import mctrl_pkg::*;

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;

   logic       mem_req;
   logic       mem_we;
   logic       iord;
   logic       ir_we;
   logic       pc_we;
   logic [1:0] pc_src;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [3:0] alu_ctl;
   logic       reg_we;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       error;
   state_e     state;

   modport master (
      input  opcode, funct, zero, mem_ready,
      output mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a,
             alu_src_b, alu_ctl, reg_we, reg_dst, mem_to_reg, error, state
   );

   modport slave (
      output opcode, funct, zero, mem_ready,
      input  mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a,
             alu_src_b, alu_ctl, reg_we, reg_dst, mem_to_reg, error, state
   );

endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ============================================================================
// Module   : alu_decoder
// Brief    : R-type funct field to ALU control code, with a valid flag for
//            unsupported funct values.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_decoder
   import mctrl_pkg::*;
(
   input  logic [5:0] funct_i,
   output logic [3:0] alu_ctl_o,
   output logic       valid_o
);

   always_comb begin
      alu_ctl_o = c_alu_add;
      valid_o   = 1'b1;
      case (funct_i)
         c_fn_add: alu_ctl_o = c_alu_add;
         c_fn_sub: alu_ctl_o = c_alu_sub;
         c_fn_and: alu_ctl_o = c_alu_and;
         c_fn_or:  alu_ctl_o = c_alu_or;
         c_fn_slt: alu_ctl_o = c_alu_slt;
         c_fn_nor: alu_ctl_o = c_alu_nor;
         default:  valid_o   = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Moore control FSM for the multicycle MIPS-subset datapath with a
//            variable-latency memory handshake and wait timeout into HALT.
//            Define MCTRL_BNE_EN to accept BNE (opcode 000101).
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl
   import mctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic              clk,
   input  logic              rst,
   multicycle_ctrl_if.master bus
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [3:0] fn_alu;
   logic       fn_valid;
   logic       in_mem;
   logic       waiting;
   logic       timeout;
   logic       bne_op;
   logic       br_take;
   ctrl_t      ctl;

   alu_decoder u_alu_decoder (
      .funct_i   (bus.funct),
      .alu_ctl_o (fn_alu),
      .valid_o   (fn_valid)
   );

   assign in_mem  = is_mem_state(state_q);
   assign waiting = in_mem && !bus.mem_ready;
   // The wait that would bring the count to TIMEOUT_CYCLES is the last one.
   assign timeout = waiting && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef MCTRL_BNE_EN
   assign bne_op = (bus.opcode == c_op_bne);
`else
   assign bne_op = 1'b0;
`endif

   assign br_take = bne_op ? !bus.zero : bus.zero;

   always_comb begin
      state_d = state_q;
      cnt_d   = waiting ? cnt_q + 1'b1 : '0;
      case (state_q)
         ST_FETCH:  if (bus.mem_ready) state_d = ST_DECODE;
         ST_DECODE: begin
            case (bus.opcode)
               c_op_lw, c_op_sw: state_d = ST_MEMADR;
               c_op_rtype:       state_d = ST_EXEC;
               c_op_beq:         state_d = ST_BRANCH;
               c_op_addi:        state_d = ST_ADDIEX;
               c_op_j:           state_d = ST_JUMP;
               default:          state_d = bne_op ? ST_BRANCH : ST_HALT;
            endcase
         end
         ST_MEMADR: state_d = (bus.opcode == c_op_sw) ? ST_MEMWR : ST_MEMRD;
         ST_MEMRD:  if (bus.mem_ready) state_d = ST_MEMWB;
         ST_MEMWB:  state_d = ST_FETCH;
         ST_MEMWR:  if (bus.mem_ready) state_d = ST_FETCH;
         ST_EXEC:   state_d = fn_valid ? ST_RWB : ST_HALT;
         ST_RWB:    state_d = ST_FETCH;
         ST_BRANCH: state_d = ST_FETCH;
         ST_ADDIEX: state_d = ST_ADDIWB;
         ST_ADDIWB: state_d = ST_FETCH;
         ST_JUMP:   state_d = ST_FETCH;
         ST_HALT:   state_d = ST_HALT;
         default:   state_d = ST_HALT;
      endcase
      if (timeout) state_d = ST_HALT;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs follow the registered state; reset overrides everything to idle.
   always_comb begin
      ctl         = '0;
      ctl.alu_ctl = c_alu_add;
      if (!rst) begin
         case (state_q)
            ST_FETCH: begin
               ctl.mem_req   = 1'b1;
               ctl.alu_src_b = c_srcb_four;
               ctl.ir_we     = bus.mem_ready;
               ctl.pc_we     = bus.mem_ready;
            end
            ST_DECODE: ctl.alu_src_b = c_srcb_immsh;
            ST_MEMADR, ST_ADDIEX: begin
               ctl.alu_src_a = 1'b1;
               ctl.alu_src_b = c_srcb_imm;
            end
            ST_MEMRD: begin
               ctl.mem_req = 1'b1;
               ctl.iord    = 1'b1;
            end
            ST_MEMWB: begin
               ctl.reg_we     = 1'b1;
               ctl.mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
               ctl.mem_req = 1'b1;
               ctl.mem_we  = 1'b1;
               ctl.iord    = 1'b1;
            end
            ST_EXEC: begin
               ctl.alu_src_a = 1'b1;
               ctl.alu_src_b = c_srcb_b;
               ctl.alu_ctl   = fn_alu;
            end
            ST_RWB: begin
               ctl.reg_we  = 1'b1;
               ctl.reg_dst = 1'b1;
            end
            ST_BRANCH: begin
               ctl.alu_src_a = 1'b1;
               ctl.alu_ctl   = c_alu_sub;
               ctl.pc_src    = c_pcsrc_aluout;
               ctl.pc_we     = br_take;
            end
            ST_ADDIWB: ctl.reg_we = 1'b1;
            ST_JUMP: begin
               ctl.pc_src = c_pcsrc_jump;
               ctl.pc_we  = 1'b1;
            end
            ST_HALT: ctl.error = 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.mem_req    = ctl.mem_req;
   assign bus.mem_we     = ctl.mem_we;
   assign bus.iord       = ctl.iord;
   assign bus.ir_we      = ctl.ir_we;
   assign bus.pc_we      = ctl.pc_we;
   assign bus.pc_src     = ctl.pc_src;
   assign bus.alu_src_a  = ctl.alu_src_a;
   assign bus.alu_src_b  = ctl.alu_src_b;
   assign bus.alu_ctl    = ctl.alu_ctl;
   assign bus.reg_we     = ctl.reg_we;
   assign bus.reg_dst    = ctl.reg_dst;
   assign bus.mem_to_reg = ctl.mem_to_reg;
   assign bus.error      = ctl.error;
   assign bus.state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Self-checking bench for multicycle_ctrl; per-cycle expected
//            outputs are built from instruction-level rules.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multicycle_ctrl;

   localparam int TIMEOUT = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;

   multicycle_ctrl_if bus ();

   multicycle_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       error;
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       ir_we;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       src_a;
      logic [1:0] src_b;
      logic [3:0] alu;
      logic       reg_we;
      logic       reg_dst;
      logic       mem_to_reg;
   } outs_t;

   typedef struct {
      outs_t      o;
      logic       rdy;
      logic       z;
      bit         chk_alu;
      logic [5:0] op;
      logic [5:0] fn;
      string      tag;
   } cyc_t;

   cyc_t       exp_q[$];
   outs_t      obs_q[$];
   logic [3:0] st_q[$];
   logic [5:0] cur_op, cur_fn;
   int         total = 0;
   int         bad   = 0;

   localparam logic [5:0] FN_LIST [6] = '{6'b100000, 6'b100010, 6'b100100,
                                          6'b100101, 6'b101010, 6'b100111};

   // ---------------- reference model ----------------
   function automatic outs_t dflt();
      outs_t o = '0;
      o.alu = 4'b0010;
      return o;
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [3:0] ref_alu(logic [5:0] fn);
      case (fn)
         6'b100000: return 4'b0010;
         6'b100010: return 4'b0110;
         6'b100100: return 4'b0000;
         6'b100101: return 4'b0001;
         6'b101010: return 4'b0111;
         6'b100111: return 4'b1100;
         default:   return 4'b0010;
      endcase
   endfunction

   function automatic bit fn_ok(logic [5:0] fn);
      return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
   endfunction

   function automatic bit bne_on();
`ifdef MCTRL_BNE_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic push(outs_t o, logic rdy, logic z, bit chk_alu, string tag);
      cyc_t c;
      c.o = o; c.rdy = rdy; c.z = z; c.chk_alu = chk_alu;
      c.op = cur_op; c.fn = cur_fn; c.tag = tag;
      exp_q.push_back(c);
   endtask

   task automatic add_halt(int n);
      outs_t o = dflt();
      o.error = 1'b1;
      for (int i = 0; i < n; i++) push(o, rbit(), rbit(), 1'b1, "halt");
   endtask

   // waits < 0 means memory never answers: TIMEOUT wait cycles, then HALT.
   task automatic add_mem(outs_t base, outs_t fin, int waits, string tag);
      int n = (waits < 0) ? TIMEOUT : waits;
      for (int i = 0; i < n; i++) push(base, 1'b0, rbit(), 1'b1, tag);
      if (waits < 0) add_halt(3);
      else           push(fin, 1'b1, rbit(), 1'b1, tag);
   endtask

   // zf: 0/1 forces the zero flag in the branch cycle, anything else randomises it.
   task automatic add_instr(logic [5:0] op, logic [5:0] fn, int wf, int wm, int zf);
      outs_t o, f;
      logic  z;
      cur_op = op; cur_fn = fn;
      o = dflt(); o.mem_req = 1'b1; o.src_b = 2'b01;
      f = o; f.ir_we = 1'b1; f.pc_we = 1'b1;
      add_mem(o, f, wf, "fetch");
      if (wf < 0) return;
      o = dflt(); o.src_b = 2'b11;
      push(o, rbit(), rbit(), 1'b1, "decode");
      if (op == 6'b100011 || op == 6'b101011) begin
         o = dflt(); o.src_a = 1'b1; o.src_b = 2'b10;
         push(o, rbit(), rbit(), 1'b1, "memadr");
         o = dflt(); o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = (op == 6'b101011);
         add_mem(o, o, wm, (op == 6'b101011) ? "memwr" : "memrd");
         if (wm >= 0 && op == 6'b100011) begin
            o = dflt(); o.reg_we = 1'b1; o.mem_to_reg = 1'b1;
            push(o, rbit(), rbit(), 1'b1, "memwb");
         end
      end else if (op == 6'b000000) begin
         o = dflt(); o.src_a = 1'b1; o.src_b = 2'b00; o.alu = ref_alu(fn);
         push(o, rbit(), rbit(), fn_ok(fn), "exec");
         if (fn_ok(fn)) begin
            o = dflt(); o.reg_we = 1'b1; o.reg_dst = 1'b1;
            push(o, rbit(), rbit(), 1'b1, "rwb");
         end else add_halt(3);
      end else if (op == 6'b000100 || (op == 6'b000101 && bne_on())) begin
         z = (zf == 0 || zf == 1) ? 1'(zf) : rbit();
         o = dflt(); o.src_a = 1'b1; o.alu = 4'b0110; o.pc_src = 2'b01;
         o.pc_we = (op == 6'b000101) ? ~z : z;
         push(o, rbit(), z, 1'b1, "branch");
      end else if (op == 6'b001000) begin
         o = dflt(); o.src_a = 1'b1; o.src_b = 2'b10;
         push(o, rbit(), rbit(), 1'b1, "addiex");
         o = dflt(); o.reg_we = 1'b1;
         push(o, rbit(), rbit(), 1'b1, "addiwb");
      end else if (op == 6'b000010) begin
         o = dflt(); o.pc_src = 2'b10; o.pc_we = 1'b1;
         push(o, rbit(), rbit(), 1'b1, "jump");
      end else add_halt(3);
   endtask

   // ---------------- drivers ----------------
   function automatic outs_t sample();
      outs_t s;
      s.error = bus.error;   s.mem_req = bus.mem_req; s.mem_we = bus.mem_we;
      s.iord = bus.iord;     s.ir_we = bus.ir_we;     s.pc_we = bus.pc_we;
      s.pc_src = bus.pc_src; s.src_a = bus.alu_src_a; s.src_b = bus.alu_src_b;
      s.alu = bus.alu_ctl;   s.reg_we = bus.reg_we;   s.reg_dst = bus.reg_dst;
      s.mem_to_reg = bus.mem_to_reg;
      return s;
   endfunction

   task automatic play();
      obs_q.delete();
      st_q.delete();
      foreach (exp_q[i]) begin
         outs_t g;
         bus.opcode = exp_q[i].op; bus.funct = exp_q[i].fn;
         bus.mem_ready = exp_q[i].rdy; bus.zero = exp_q[i].z;
         @(negedge clk);
         g = sample();
         if (!exp_q[i].chk_alu) g.alu = exp_q[i].o.alu;
         obs_q.push_back(g);
         st_q.push_back(4'(bus.state));
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      outs_t g;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.mem_ready = rbit(); bus.zero = rbit();
         @(negedge clk);
         g = sample(); total++;
         if (g !== dflt()) begin bad++; $display("FAIL reset_idle: got %b want %b", g, dflt()); end
         @(posedge clk); #1;
      end
      rst = 1'b0; bus.mem_ready = 1'b0;
      @(negedge clk);
      total++;
      if (4'(bus.state) !== 4'd0 || bus.mem_req !== 1'b1) begin
         bad++; $display("FAIL reset_release: state=%0d mem_req=%b want 0/1", bus.state, bus.mem_req);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (bus.mem_req !== 1'b0 || bus.error !== 1'b0) begin
         bad++; $display("FAIL reset_abandon: mem_req=%b error=%b want 0/0", bus.mem_req, bus.error);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_lw_zero_wait();
      exp_q.delete();
      add_instr(6'b100011, 6'b000000, 0, 0, 2);
      add_instr(6'b000010, 6'b000000, 0, 0, 2);
      play();
      foreach (exp_q[i]) begin
         total++;
         if (obs_q[i] !== exp_q[i].o) begin
            bad++; $display("FAIL lw_zero_wait[%0d] %s: got %b want %b", i, exp_q[i].tag, obs_q[i], exp_q[i].o);
         end
      end
      total++;
      if (st_q[5] !== 4'd0) begin bad++; $display("FAIL lw_latency: state=%0d want 0", st_q[5]); end
   endtask

   task automatic test_rtype_nor();
      exp_q.delete();
      add_instr(6'b000000, 6'b100111, 0, 0, 2);
      play();
      foreach (exp_q[i]) begin
         total++;
         if (obs_q[i] !== exp_q[i].o) begin
            bad++; $display("FAIL rtype_nor[%0d] %s: got %b want %b", i, exp_q[i].tag, obs_q[i], exp_q[i].o);
         end
      end
   endtask

   task automatic test_beq();
      exp_q.delete();
      add_instr(6'b000100, 6'b000000, 0, 0, 1);
      add_instr(6'b000100, 6'b000000, 0, 0, 0);
      play();
      foreach (exp_q[i]) begin
         total++;
         if (obs_q[i] !== exp_q[i].o) begin
            bad++; $display("FAIL beq[%0d] %s: got %b want %b", i, exp_q[i].tag, obs_q[i], exp_q[i].o);
         end
      end
   endtask

   task automatic test_fetch_delay();
      exp_q.delete();
      add_instr(6'b001000, 6'b000000, 3, 0, 2);
      add_instr(6'b101011, 6'b000000, 1, 2, 2);
      play();
      foreach (exp_q[i]) begin
         total++;
         if (obs_q[i] !== exp_q[i].o) begin
            bad++; $display("FAIL fetch_delay[%0d] %s: got %b want %b", i, exp_q[i].tag, obs_q[i], exp_q[i].o);
         end
      end
   endtask

   task automatic test_timeout();
      exp_q.delete();
      add_instr(6'b100011, 6'b000000, 0, TIMEOUT - 1, 2);
      add_instr(6'b100011, 6'b000000, 0, -1, 2);
      play();
      foreach (exp_q[i]) begin
         total++;
         if (obs_q[i] !== exp_q[i].o) begin
            bad++; $display("FAIL timeout[%0d] %s: got %b want %b", i, exp_q[i].tag, obs_q[i], exp_q[i].o);
         end
      end
      do_reset();
      bus.mem_ready = 1'b0;
      @(negedge clk);
      total++;
      if (bus.error !== 1'b0 || 4'(bus.state) !== 4'd0) begin
         bad++; $display("FAIL timeout_recover: error=%b state=%0d want 0/0", bus.error, bus.state);
      end
      @(posedge clk); #1;
      do_reset();
   endtask

   task automatic test_illegal();
      logic [5:0] ops [3] = '{6'b000101, 6'b111111, 6'b000000};
      for (int k = 0; k < 3; k++) begin
         exp_q.delete();
         add_instr(ops[k], 6'b000000, 0, 0, 0);
         play();
         foreach (exp_q[i]) begin
            total++;
            if (obs_q[i] !== exp_q[i].o) begin
               bad++; $display("FAIL illegal_op%b[%0d] %s: got %b want %b", ops[k], i, exp_q[i].tag, obs_q[i], exp_q[i].o);
            end
         end
         do_reset();
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                              6'b001000, 6'b000010, 6'b000101};
      int starts[$];
      int nops = bne_on() ? 7 : 6;
      exp_q.delete();
      for (int n = 0; n < 30; n++) begin
         int wf = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
         int wm = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
         starts.push_back(exp_q.size());
         add_instr(ops[$urandom_range(0, nops - 1)], FN_LIST[$urandom_range(0, 5)], wf, wm, 2);
      end
      play();
      foreach (exp_q[i]) begin
         total++;
         if (obs_q[i] !== exp_q[i].o) begin
            bad++; $display("FAIL b2b[%0d] %s op=%b: got %b want %b", i, exp_q[i].tag, exp_q[i].op, obs_q[i], exp_q[i].o);
         end
      end
      foreach (starts[i]) begin
         total++;
         if (st_q[starts[i]] !== 4'd0) begin
            bad++; $display("FAIL b2b_start[%0d]: state=%0d want 0", i, st_q[starts[i]]);
         end
      end
   endtask

   initial begin
      bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
      cur_op = '0; cur_fn = '0;
      @(posedge clk); #1;
      test_reset();
      test_lw_zero_wait();
      test_rtype_nor();
      test_beq();
      test_fetch_delay();
      test_timeout();
      test_illegal();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style control FSM for the multicycle MIPS-subset datapath. It sequences the shared 32-bit ALU through fetch, decode, execute, memory and writeback, and drives the `alu_ctl` code, mux selects and write enables. It handshakes with a variable-latency memory port. It sits between the instruction register (`opcode`/`funct` fields), the ALU `zero` flag and the datapath enables.

## Interface
- `TIMEOUT_CYCLES`, 15: maximum cycles a memory state may wait for `mem_ready` before entering HALT.

- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write access.
- `iord` out 1: 0 = PC address, 1 = ALUOut address.
- `ir_we` out 1: load instruction register.
- `pc_we` out 1: load PC.
- `pc_src` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_src_a` out 1: 0 = PC, 1 = A register.
- `alu_src_b` out 2: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `alu_ctl` out 4: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- `reg_we` out 1: register file write enable.
- `reg_dst` out 1: 0 = rt, 1 = rd.
- `mem_to_reg` out 1: 1 = write MDR, 0 = write ALUOut.
- `error` out 1: sticky, high while in HALT.
- `state` out 4: current state encoding (debug).

## Operation
- Supported opcodes: R-type 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- Supported R-type funct: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010, NOR 100111.
- Any other opcode in DECODE, or any other funct in EXEC, goes to HALT.
- Default outputs in every state: all enables 0, all selects 0, `alu_ctl` = 0010. Each state below lists only its deviations from the defaults.
- **FETCH:** `mem_req` = 1, `iord` = 0, `alu_src_b` = 01. When `mem_ready` = 1: `ir_we` = 1, `pc_we` = 1 (PC += 4), then go to DECODE.
- **DECODE:** `alu_src_b` = 11, ADD (branch target into ALUOut). Next state by opcode: LW/SW → MEMADR, R → EXEC, BEQ → BRANCH, ADDI → ADDIEX, J → JUMP.
- **MEMADR:** `alu_src_a` = 1, `alu_src_b` = 10, ADD. Go to MEMRD for LW, MEMWR for SW.
- **MEMRD:** `mem_req` = 1, `iord` = 1. Go to MEMWB on `mem_ready`.
- **MEMWB:** `reg_we` = 1, `mem_to_reg` = 1, `reg_dst` = 0. Go to FETCH.
- **MEMWR:** `mem_req` = 1, `mem_we` = 1, `iord` = 1. Go to FETCH on `mem_ready`.
- **EXEC:** `alu_src_a` = 1, `alu_src_b` = 00, `alu_ctl` = decode(`funct`). Go to RWB.
- **RWB:** `reg_we` = 1, `reg_dst` = 1. Go to FETCH.
- **BRANCH:** `alu_src_a` = 1, SUB, `pc_src` = 01, `pc_we` = `zero`. Go to FETCH.
- **ADDIEX:** `alu_src_a` = 1, `alu_src_b` = 10, ADD. Go to ADDIWB.
- **ADDIWB:** `reg_we` = 1, `reg_dst` = 0. Go to FETCH.
- **JUMP:** `pc_src` = 10, `pc_we` = 1. Go to FETCH.
- **HALT:** all enables 0, `error` = 1. Exit only via `rst`.

## Timing
- State is registered; outputs are decoded from the registered state, plus `mem_ready`/`zero` where noted above.
- `mem_ready` is sampled in the same cycle `mem_req` is high; a one-cycle (zero-wait) access is legal.
- While waiting for `mem_ready`, `mem_req` and all address/data selects hold steady.
- Wait counter:
  - Clears on entry to any memory state.
  - Increments each cycle `mem_req` = 1 and `mem_ready` = 0.
  - Reaching `TIMEOUT_CYCLES` moves the FSM to HALT on the next edge.
- Latency with zero-wait memory: LW 5 cycles; SW, R-type and ADDI 4; BEQ and J 3.
- Reset:
  - While `rst` = 1, all outputs are forced to idle values (all enables 0, `error` = 0).
  - On the next edge: state = FETCH, counter = 0.
  - Reset mid-access abandons the access by dropping `mem_req`; the memory side tolerates this.
- `mem_ready` asserted outside a memory state is ignored.

## Configuration
- Macro `MCTRL_BNE_EN`.
- Defined: opcode 000101 (BNE) decodes to BRANCH with `pc_we` = ~`zero`.
- Undefined: BNE is an illegal opcode and goes to HALT.

## Structure
- Package `mctrl_pkg`:
  - state encoding (FETCH = 0)
  - opcode and funct constants
  - `alu_ctl` codes
  - `pc_src` and `alu_src_b` encodings
- Sub-module `alu_decoder`: combinational mapping `funct` → {`alu_ctl`, `valid`}, instantiated once.

## Test plan
- LW, zero-wait memory: FETCH, DECODE, MEMADR, MEMRD, MEMWB, then FETCH. `ir_we` and `pc_we` pulse in cycle 1; `reg_we` = 1 with `mem_to_reg` = 1 in cycle 5.
- R-type `funct` = 100111 (NOR): `alu_ctl` = 1100 in EXEC; `reg_we` = 1 with `reg_dst` = 1 in the next cycle.
- BEQ with `zero` = 1: `pc_we` = 1 and `pc_src` = 01 in BRANCH. With `zero` = 0: `pc_we` = 0.
- Fetch with `mem_ready` delayed 3 cycles: `mem_req` held 4 cycles; `ir_we` = 1 only in the 4th.
- `mem_ready` never asserted in MEMRD: HALT after 15 wait cycles, `error` = 1. Asserting `rst` returns the FSM to FETCH with `error` = 0.
- Opcode 000101: HALT when `MCTRL_BNE_EN` is undefined; with it defined and `zero` = 0, `pc_we` = 1.
